// File: rtl/pimac_result_uart_tx.sv
// PiMAC result serializer: buffers MAC result words in a small FIFO and
// streams each one off-chip as an 8N1 UART frame, LSB first.
//
// Handshake: a word is written on any rising edge where in_valid && in_ready.
// in_ready depends only on registered state. When the FIFO is full, in_ready
// stays low even if a word is popped in the same cycle. A word offered while
// in_ready is low is dropped and sets the sticky overflow flag.
module pimac_result_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    output logic                          ser_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [1:0]                    debug_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cyc_q, cyc_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    ser_q, ser_d;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q;
    logic                    overflow_q;
    logic                    push, pop;

    assign in_ready    = (level_q != LVL_FULL);
    assign push        = in_valid && in_ready;
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;
    assign ser_out     = ser_q;
    assign busy        = (state_q != IDLE);
    assign debug_state = state_q;

    // Storage has no reset: the pointers and level alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (in_valid && !in_ready) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ser_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ser_q   <= ser_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        ser_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    cyc_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cyc_q == CNT_LAST) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DATA: begin
                if (cyc_q == CNT_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            STOP: begin
                if (cyc_q == CNT_LAST) begin
                    cyc_d = '0;
                    // Chain straight into the next start bit when more words wait.
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
            end
        endcase

        // The line level is registered, so it is decoded from the upcoming state.
        case (state_d)
            START:   ser_d = 1'b0;
            DATA:    ser_d = shift_d[0];
            default: ser_d = 1'b1;
        endcase
    end

endmodule
